// File: rtl/mypkg.sv
// rtl/mypkg.sv - shared ALU opcode enum, RV32I opcode/funct7 constants and the issue packet.
package mypkg;

   typedef enum logic [3:0] {
      A_ADD  = 4'd0,
      A_SUB  = 4'd1,
      A_SLL  = 4'd2,
      A_SLT  = 4'd3,
      A_SLTU = 4'd4,
      A_XOR  = 4'd5,
      A_SRL  = 4'd6,
      A_SRA  = 4'd7,
      A_OR   = 4'd8,
      A_AND  = 4'd9,
      A_LUI  = 4'd10
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   typedef struct packed {
      alu_op_e     alu_op;
      logic [31:0] operand_a;
      logic [31:0] operand_b;
      logic [4:0]  rd_addr;
      logic        rd_we;
      logic        illegal;
   } issue_pkt_t;

   localparam issue_pkt_t ISSUE_PKT_RESET = '{
      alu_op:    A_ADD,
      operand_a: 32'h0,
      operand_b: 32'h0,
      rd_addr:   5'd0,
      rd_we:     1'b0,
      illegal:   1'b0
   };

   // Operation selected by funct3 when funct7 is the base encoding (OP and OP-IMM share it).
   function automatic alu_op_e base_op(input logic [2:0] funct3);
      case (funct3)
         3'b000:  base_op = A_ADD;
         3'b001:  base_op = A_SLL;
         3'b010:  base_op = A_SLT;
         3'b011:  base_op = A_SLTU;
         3'b100:  base_op = A_XOR;
         3'b101:  base_op = A_SRL;
         3'b110:  base_op = A_OR;
         default: base_op = A_AND;
      endcase
   endfunction

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational RV32I OP/OP-IMM/LUI/AUIPC decode into an issue packet.
module instr_decode
   import mypkg::*;
(
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] rs1_data_i,
   input  logic [31:0] rs2_data_i,
   output issue_pkt_t  pkt_o
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic [31:0] imm_i;
   logic [31:0] imm_u;
   logic [31:0] shamt;
   logic        unused_rs1_field;

   assign opcode = instr_i[6:0];
   assign rd     = instr_i[11:7];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];
   assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
   assign imm_u  = {instr_i[31:12], 12'h000};
   assign shamt  = {27'd0, instr_i[24:20]};
   // rs1 is consumed through rs1_data_i; its address field is not needed here.
   assign unused_rs1_field = ^instr_i[19:15];

   alu_op_e     op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        ill;

   always_comb begin
      op   = A_ADD;
      op_a = 32'h0;
      op_b = 32'h0;
      ill  = 1'b0;
      case (opcode)
         OPC_OP: begin
            op_a = rs1_data_i;
            op_b = rs2_data_i;
            if (funct7 == F7_BASE) begin
               op = base_op(funct3);
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               op = A_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
               op = A_SRA;
            end else begin
               ill = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            op_a = rs1_data_i;
            op_b = imm_i;
            op   = base_op(funct3);
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               op_b = shamt;
               if (funct3 == 3'b101 && funct7 == F7_ALT) begin
                  op = A_SRA;
               end else if (funct7 != F7_BASE) begin
                  ill = 1'b1;
               end
            end
         end
         OPC_LUI: begin
            op   = A_LUI;
            op_b = imm_u;
         end
         OPC_AUIPC: begin
            op_a = pc_i;
            op_b = imm_u;
         end
         default: ill = 1'b1;
      endcase
   end

   always_comb begin
      pkt_o         = ISSUE_PKT_RESET;
      pkt_o.illegal = ill;
      if (!ill) begin
         pkt_o.alu_op    = op;
         pkt_o.operand_a = op_a;
         pkt_o.operand_b = op_b;
         pkt_o.rd_addr   = rd;
         pkt_o.rd_we     = (rd != 5'd0);
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - decode/issue stage: fetch handshake in, registered ALU issue out.
// ALU_ISSUE_SKID_EN adds one skid entry so instr_ready_o comes straight from a flop.
module alu_issue_stage
   import mypkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_valid_i,
   output logic        instr_ready_o,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   output logic [4:0]  rs1_addr_o,
   output logic [4:0]  rs2_addr_o,
   input  logic [31:0] rs1_data_i,
   input  logic [31:0] rs2_data_i,
   output logic        issue_valid_o,
   input  logic        issue_ready_i,
   output alu_op_e     alu_op_o,
   output logic [31:0] operand_a_o,
   output logic [31:0] operand_b_o,
   output logic [4:0]  rd_addr_o,
   output logic        rd_we_o,
   output logic        illegal_o
);

   issue_pkt_t dec_pkt;
   issue_pkt_t out_q, out_d;
   logic       out_valid_q, out_valid_d;
   logic       accept;
   logic       consume;

   assign rs1_addr_o = instr_i[19:15];
   assign rs2_addr_o = instr_i[24:20];

   instr_decode u_decode (
      .instr_i    (instr_i),
      .pc_i       (pc_i),
      .rs1_data_i (rs1_data_i),
      .rs2_data_i (rs2_data_i),
      .pkt_o      (dec_pkt)
   );

   assign accept  = instr_valid_i && instr_ready_o;
   assign consume = out_valid_q && issue_ready_i;

`ifdef ALU_ISSUE_SKID_EN
   issue_pkt_t skid_q, skid_d;
   logic       skid_valid_q, skid_valid_d;

   assign instr_ready_o = !skid_valid_q;

   // While skid is occupied no accept can happen, so only the drain path is live.
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (skid_valid_q) begin
         if (consume) begin
            out_d        = skid_q;
            skid_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (out_valid_q && !issue_ready_i) begin
            skid_d       = dec_pkt;
            skid_valid_d = 1'b1;
         end else begin
            out_d       = dec_pkt;
            out_valid_d = 1'b1;
         end
      end else if (consume) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         skid_q       <= ISSUE_PKT_RESET;
         skid_valid_q <= 1'b0;
      end else begin
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end
`else
   assign instr_ready_o = !out_valid_q || issue_ready_i;

   always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      if (accept) begin
         out_d       = dec_pkt;
         out_valid_d = 1'b1;
      end else if (consume) begin
         out_valid_d = 1'b0;
      end
   end
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_q       <= ISSUE_PKT_RESET;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign issue_valid_o = out_valid_q;
   assign alu_op_o      = out_q.alu_op;
   assign operand_a_o   = out_q.operand_a;
   assign operand_b_o   = out_q.operand_b;
   assign rd_addr_o     = out_q.rd_addr;
   assign rd_we_o       = out_q.rd_we;
   assign illegal_o     = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage (base or ALU_ISSUE_SKID_EN).
module tb_alu_issue_stage;
   import mypkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        issue_valid;
   logic        issue_ready;
   alu_op_e     alu_op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  rd_addr;
   logic        rd_we;
   logic        illegal;

   logic [31:0] regs [32];
   issue_pkt_t  obs;
   logic [70:0] obs_ill;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   always #5 clk = ~clk;

   assign rs1_data = regs[rs1_addr];
   assign rs2_data = regs[rs2_addr];
   assign obs      = {alu_op, op_a, op_b, rd_addr, rd_we, illegal};
   assign obs_ill  = {alu_op, op_a, op_b, rd_we, illegal};

   alu_issue_stage dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .instr_valid_i (instr_valid),
      .instr_ready_o (instr_ready),
      .instr_i       (instr),
      .pc_i          (pc),
      .rs1_addr_o    (rs1_addr),
      .rs2_addr_o    (rs2_addr),
      .rs1_data_i    (rs1_data),
      .rs2_data_i    (rs2_data),
      .issue_valid_o (issue_valid),
      .issue_ready_i (issue_ready),
      .alu_op_o      (alu_op),
      .operand_a_o   (op_a),
      .operand_b_o   (op_b),
      .rd_addr_o     (rd_addr),
      .rd_we_o       (rd_we),
      .illegal_o     (illegal)
   );

   function automatic issue_pkt_t mk(alu_op_e op, logic [31:0] a, logic [31:0] b,
                                     logic [4:0] rd, logic we);
      mk.alu_op    = op;
      mk.operand_a = a;
      mk.operand_b = b;
      mk.rd_addr   = rd;
      mk.rd_we     = we;
      mk.illegal   = 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      instr_valid = 1'b0;
      instr = 32'h0;
      pc = 32'h0;
      issue_ready = 1'b1;
      #2;
      total_cnt++;
      if (issue_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", issue_valid);
      else pass_cnt++;
      total_cnt++;
      if (instr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", instr_ready);
      else pass_cnt++;
      tick();
      tick();
      total_cnt++;
      if (obs !== ISSUE_PKT_RESET) $display("FAIL reset_fields: got %h want %h", obs, ISSUE_PKT_RESET);
      else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_add();
      instr_valid = 1'b1;
      instr = 32'h002081B3;
      tick();
      instr_valid = 1'b0;
      total_cnt++;
      if (issue_valid !== 1'b1) $display("FAIL add_valid: got %b want 1", issue_valid);
      else pass_cnt++;
      total_cnt++;
      if (obs !== mk(A_ADD, 32'd5, 32'd7, 5'd3, 1'b1))
         $display("FAIL add_fields: got %h want %h", obs, mk(A_ADD, 32'd5, 32'd7, 5'd3, 1'b1));
      else pass_cnt++;
      tick();
      total_cnt++;
      if (issue_valid !== 1'b0) $display("FAIL add_drop: got %b want 0", issue_valid);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      instr_valid = 1'b1;
      instr = 32'h402081B3;
      tick();
      instr = 32'h4043D313;
      total_cnt++;
      if (obs !== mk(A_SUB, 32'd5, 32'd7, 5'd3, 1'b1) || issue_valid !== 1'b1)
         $display("FAIL b2b_sub: got %h want %h", obs, mk(A_SUB, 32'd5, 32'd7, 5'd3, 1'b1));
      else pass_cnt++;
      tick();
      instr_valid = 1'b0;
      total_cnt++;
      if (obs !== mk(A_SRA, 32'h80, 32'd4, 5'd6, 1'b1) || issue_valid !== 1'b1)
         $display("FAIL b2b_srai: got %h want %h", obs, mk(A_SRA, 32'h80, 32'd4, 5'd6, 1'b1));
      else pass_cnt++;
      tick();
   endtask

   task automatic test_imm();
      logic [31:0] ins [4];
      logic [31:0] pcs [4];
      issue_pkt_t  exp [4];
      ins[0] = 32'hFFF00013; pcs[0] = 32'h0;   exp[0] = mk(A_ADD, 32'h0, 32'hFFFFFFFF, 5'd0, 1'b0);
      ins[1] = 32'h123450B7; pcs[1] = 32'h0;   exp[1] = mk(A_LUI, 32'h0, 32'h12345000, 5'd1, 1'b1);
      ins[2] = 32'h00001097; pcs[2] = 32'h100; exp[2] = mk(A_ADD, 32'h100, 32'h1000, 5'd1, 1'b1);
      ins[3] = 32'h00311293; pcs[3] = 32'h0;   exp[3] = mk(A_SLL, 32'd7, 32'd3, 5'd5, 1'b1);
      for (int i = 0; i < 4; i++) begin
         instr_valid = 1'b1;
         instr = ins[i];
         pc = pcs[i];
         tick();
         total_cnt++;
         if (obs !== exp[i] || issue_valid !== 1'b1)
            $display("FAIL imm_%0d: got %h want %h", i, obs, exp[i]);
         else pass_cnt++;
      end
      instr_valid = 1'b0;
      pc = 32'h0;
      tick();
   endtask

   task automatic test_illegal();
      logic [31:0] ins [3];
      logic [70:0] want;
      ins[0] = 32'h0000007F;
      ins[1] = 32'h202081B3;
      ins[2] = 32'h40311293;
      want = {A_ADD, 64'h0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         instr_valid = 1'b1;
         instr = ins[i];
         tick();
         total_cnt++;
         if (obs_ill !== want || issue_valid !== 1'b1)
            $display("FAIL illegal_%0d: got %h want %h", i, obs_ill, want);
         else pass_cnt++;
      end
      instr_valid = 1'b0;
      tick();
   endtask

   task automatic test_stall();
      logic [31:0] ins [3];
      issue_pkt_t  exp [3];
      logic        exp_rdy [3];
      logic        r;
      int          idx;
      int          got;
      ins[0] = 32'h002081B3; exp[0] = mk(A_ADD, 32'd5, 32'd7, 5'd3, 1'b1);
      ins[1] = 32'h123450B7; exp[1] = mk(A_LUI, 32'h0, 32'h12345000, 5'd1, 1'b1);
      ins[2] = 32'h00108213; exp[2] = mk(A_ADD, 32'd5, 32'd1, 5'd4, 1'b1);
      exp_rdy[0] = 1'b1;
`ifdef ALU_ISSUE_SKID_EN
      exp_rdy[1] = 1'b1;
`else
      exp_rdy[1] = 1'b0;
`endif
      exp_rdy[2] = 1'b0;
      idx = 0;
      issue_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         instr_valid = 1'b1;
         instr = ins[idx];
         @(negedge clk);
         r = instr_ready;
         total_cnt++;
         if (r !== exp_rdy[c]) $display("FAIL stall_ready_%0d: got %b want %b", c, r, exp_rdy[c]);
         else pass_cnt++;
         if (c > 0) begin
            total_cnt++;
            if (obs !== exp[0] || issue_valid !== 1'b1)
               $display("FAIL stall_hold_%0d: got %h want %h", c, obs, exp[0]);
            else pass_cnt++;
         end
         @(posedge clk);
         if (r) idx++;
         #1;
      end
      issue_ready = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
         instr_valid = (idx < 3);
         instr = (idx < 3) ? ins[idx] : 32'h0;
         @(negedge clk);
         r = instr_ready && instr_valid;
         if (issue_valid) begin
            total_cnt++;
            if (obs !== exp[got]) $display("FAIL drain_%0d: got %h want %h", got, obs, exp[got]);
            else pass_cnt++;
            got++;
         end
         @(posedge clk);
         if (r) idx++;
         #1;
      end
      instr_valid = 1'b0;
      total_cnt++;
      if (got !== 3) $display("FAIL drain_count: got %0d want 3", got);
      else pass_cnt++;
      total_cnt++;
      if (issue_valid !== 1'b0) $display("FAIL drain_empty: got %b want 0", issue_valid);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      issue_ready = 1'b0;
      instr_valid = 1'b1;
      instr = 32'h002081B3;
      tick();
      instr = 32'h123450B7;
      tick();
      instr_valid = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      total_cnt++;
      if (issue_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", issue_valid);
      else pass_cnt++;
      total_cnt++;
      if (instr_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", instr_ready);
      else pass_cnt++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      issue_ready = 1'b1;
      instr_valid = 1'b1;
      instr = 32'h00108213;
      tick();
      instr_valid = 1'b0;
      total_cnt++;
      if (obs !== mk(A_ADD, 32'd5, 32'd1, 5'd4, 1'b1) || issue_valid !== 1'b1)
         $display("FAIL rstmid_next: got %h want %h", obs, mk(A_ADD, 32'd5, 32'd1, 5'd4, 1'b1));
      else pass_cnt++;
      tick();
      total_cnt++;
      if (issue_valid !== 1'b0) $display("FAIL rstmid_noreplay: got %b want 0", issue_valid);
      else pass_cnt++;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h0;
      regs[1] = 32'd5;
      regs[2] = 32'd7;
      regs[7] = 32'h80;
      test_reset();
      test_add();
      test_back_to_back();
      test_imm();
      test_illegal();
      test_stall();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
